// File: rtl/bin2bcd_seq.sv
// Purpose : iterative shift-and-add-3 (double-dabble) binary-to-BCD converter, one input bit per clock.
// Latency : BIN_W+1 cycles from accepted start to done; FIN returns to IDLE, so back-to-back accepts are BIN_W+2 cycles apart.
// Backpr. : none queued; start is sampled only in IDLE and ignored while busy.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    conversion request, sampled only in IDLE
//   bin_in   binary operand, captured on the accepting edge
//   busy     high while SHIFT or FIN
//   done     one-cycle pulse, bcd_out freshly updated
//   bcd_out  packed BCD result, digit 0 in [3:0], held until the next done
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   bin_sh_q;
  logic [BCD_W-1:0]   bcd_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_out_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_sh_d;
  logic [BIN_W-1:0]   bin_sh_d;

  // Per-digit add-3 correction; each nibble wraps within itself so no
  // correction ever carries into the neighbouring digit.
  always_comb begin
    bcd_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_sh_q[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_sh_q[4*d +: 4] + 4'd3;
      end else begin
        bcd_adj[4*d +: 4] = bcd_sh_q[4*d +: 4];
      end
    end
  end

  // Shift {bcd, bin} left by one; the bcd MSB falls off (only reachable on
  // parameter misuse) and the binary LSB fills with zero.
  always_comb begin
    bcd_sh_d = {bcd_adj[BCD_W-2:0], bin_sh_q[BIN_W-1]};
    bin_sh_d = bin_sh_q << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_sh_q  <= '0;
      bcd_sh_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            bin_sh_q <= bin_in;
            bcd_sh_q <= '0;
            cnt_q    <= CNT_W'(BIN_W);
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        SHIFT: begin
          bin_sh_q <= bin_sh_d;
          bcd_sh_q <= bcd_sh_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          busy_q   <= 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            // Last bit: publish the fully shifted value on the FIN entry edge.
            bcd_out_q <= bcd_sh_d;
            done_q    <= 1'b1;
            state_q   <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];
  logic        prev_done = 1'b0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: independent of the shift algorithm.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] d0, d1, d2;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    return {d2, d1, d0};
  endfunction

  // Monitor: pop the scoreboard on every done, check value, digit range, pulse width.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_pulse: done high two cycles in a row");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: bcd_out=%0h with empty scoreboard", bcd_out);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (bcd_out !== e) begin
          errors++;
          $display("FAIL bcd_out: got %0h expected %0h", bcd_out, e);
        end
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (bcd_out[4*d +: 4] > 4'd9) begin
          errors++;
          $display("FAIL digit_range: digit %0d = %0h", d, bcd_out[4*d +: 4]);
        end
      end
    end
    prev_done = rst_n && done;
  end

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (!busy && !done) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout busy=%0b done=%0b", busy, done);
    end
  endtask

  // Counts negedges after the accept edge until done; returns cycle index and busy count.
  task automatic watch_done(output int k, output int busy_n);
    bit seen;
    seen = 0;
    k = 0;
    busy_n = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        seen = 1;
        k = c;
      end
    end
  endtask

  task automatic conv(input logic [7:0] v, input logic [11:0] e);
    int k, bn;
    wait_idle();
    bin_in = v;
    start  = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = 8'($urandom);
    watch_done(k, bn);
    chk("latency", 32'(k), 32'd9);
    chk("busy_cycles", 32'(bn), 32'd9);
  endtask

  initial begin
    int k, bn;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bcd", 32'(bcd_out), 32'd0);
    rst_n = 1'b1;

    // 1, 2: directed values with hand-computed BCD.
    conv(8'd255, 12'h255);
    chk("hold_after_done", 32'(bcd_out), 32'h255);
    conv(8'd0,   12'h000);
    conv(8'd99,  12'h099);
    conv(8'd100, 12'h100);

    // 3: start during SHIFT is ignored.
    wait_idle();
    bin_in = 8'd42;
    start  = 1'b1;
    exp_q.push_back(12'h042);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    bin_in = 8'd7;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    watch_done(k, bn);
    chk("ignored_start_latency", 32'(k), 32'd5);
    repeat (15) @(negedge clk);
    chk("ignored_start_queue", 32'(exp_q.size()), 32'd0);

    // 4: start held high, back-to-back conversions with one idle cycle between.
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] v;
      v = (i % 2 == 0) ? 8'd128 : 8'd9;
      bin_in = v;
      exp_q.push_back((i % 2 == 0) ? 12'h128 : 12'h009);
      @(posedge clk);
      #1;
      bin_in = 8'd200;
      watch_done(k, bn);
      chk("b2b_latency", 32'(k), 32'd9);
      @(negedge clk);
      chk("b2b_idle_gap", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    // One extra conversion was accepted on that edge (bin_in=200).
    exp_q.push_back(12'h200);
    watch_done(k, bn);
    chk("b2b_tail_latency", 32'(k), 32'd9);

    // 5: reset mid-conversion aborts at once, and no done follows.
    wait_idle();
    bin_in = 8'd77;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done_bcd", 32'(bcd_out), 32'd0);

    // 6: exhaustive against the decimal reference.
    for (int v = 0; v < 256; v++) begin
      conv(8'(v), ref_bcd(v));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
